// File: rtl/motion_pkg.sv
// Shared types and default widths for the motion detector and its upstream control.
package motion_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 8;
  localparam int unsigned DEF_COUNT_WIDTH    = 20;
  localparam int unsigned DEF_FRAME_ID_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } motion_state_t;

endpackage

// File: rtl/motion_detector_if.sv
// Difference-pixel stream in, per-frame motion report out.
interface motion_detector_if
  import motion_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned COUNT_WIDTH    = DEF_COUNT_WIDTH,
  parameter int unsigned FRAME_ID_WIDTH = DEF_FRAME_ID_WIDTH
);

  logic [DATA_WIDTH-1:0]     diff_data;
  logic                      diff_valid;
  logic                      sof;
  logic                      eof;
  logic                      motion_valid;
  logic                      motion_ready;
  logic                      motion_detected;
  logic [COUNT_WIDTH-1:0]    motion_count;
  logic [FRAME_ID_WIDTH-1:0] frame_id;

  // Upstream/control side: drives pixels and accepts reports.
  modport master (
    output diff_data, diff_valid, sof, eof, motion_ready,
    input  motion_valid, motion_detected, motion_count, frame_id
  );

  // Detector side.
  modport slave (
    input  diff_data, diff_valid, sof, eof, motion_ready,
    output motion_valid, motion_detected, motion_count, frame_id
  );

endinterface

// File: rtl/sat_counter.sv
// Loadable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next_c
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  // Next value: load wins over increment; increment stops at the maximum.
  always_comb begin
    count_next_c = count;
    if (load) begin
      count_next_c = load_value;
    end else if (inc && (count != MAX_COUNT)) begin
      count_next_c = count + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_next_c;
    end
  end

endmodule

// File: rtl/motion_detector.sv
// Counts above-threshold difference pixels per frame and reports motion once per frame.
module motion_detector
  import motion_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned COUNT_WIDTH    = DEF_COUNT_WIDTH,
  parameter int unsigned FRAME_ID_WIDTH = DEF_FRAME_ID_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  motion_detector_if.slave       bus,
  input  logic [DATA_WIDTH-1:0]  pixel_threshold,
  input  logic [COUNT_WIDTH-1:0] count_threshold,
  output logic                   frame_error
);

  motion_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0]  pix_thr_q;
  logic [COUNT_WIDTH-1:0] cnt_thr_q;
  logic [DATA_WIDTH-1:0]  pix_thr_eff_c;
  logic [COUNT_WIDTH-1:0] cnt_thr_eff_c;
  logic                   hit_c;
  logic                   cnt_load, cnt_inc, latch_thr, err_d, report_d, xfer;
  logic [COUNT_WIDTH-1:0] count, count_next_c;

  // A sof beat is judged against the thresholds presented with it, others against the latched ones.
  always_comb begin
    pix_thr_eff_c = bus.sof ? pixel_threshold : pix_thr_q;
    cnt_thr_eff_c = bus.sof ? count_threshold : cnt_thr_q;
    hit_c         = bus.diff_data > pix_thr_eff_c;
  end

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_hits (
    .clk          (clk),
    .reset        (reset),
    .load         (cnt_load),
    .load_value   (COUNT_WIDTH'(hit_c)),
    .inc          (cnt_inc),
    .count        (count),
    .count_next_c (count_next_c)
  );

  assign bus.motion_count = count;

  // Frame tracking: next state and per-beat controls.
  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    latch_thr = 1'b0;
    err_d     = 1'b0;
    report_d  = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.diff_valid) begin
          if (bus.sof) begin
            latch_thr = 1'b1;
            cnt_load  = 1'b1;
            report_d  = bus.eof;
            state_d   = bus.eof ? REPORT : ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACCUM: begin
        if (bus.diff_valid) begin
          if (bus.sof) begin
            err_d     = 1'b1;
            latch_thr = 1'b1;
            cnt_load  = 1'b1;
          end else begin
            cnt_inc = hit_c;
          end
          if (bus.eof) begin
            report_d = 1'b1;
            state_d  = REPORT;
          end
        end
      end
      REPORT: begin
        err_d = bus.diff_valid;
        if (bus.motion_valid && bus.motion_ready) begin
          xfer    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched thresholds and registered report outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= IDLE;
      pix_thr_q           <= '0;
      cnt_thr_q           <= '0;
      bus.motion_valid    <= 1'b0;
      bus.motion_detected <= 1'b0;
      bus.frame_id        <= '0;
      frame_error         <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus.motion_valid <= (state_d == REPORT);
      frame_error      <= err_d;
      if (latch_thr) begin
        pix_thr_q <= pixel_threshold;
        cnt_thr_q <= count_threshold;
      end
      if (report_d) begin
        bus.motion_detected <= (count_next_c >= cnt_thr_eff_c);
      end else if (xfer) begin
        bus.motion_detected <= 1'b0;
      end
      if (xfer) begin
        bus.frame_id <= bus.frame_id + FRAME_ID_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_motion_detector.sv
// Directed bench: two detectors (20-bit and 4-bit counters) share one stimulus stream.
module tb_motion_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  pt = '0;
  logic [19:0] ct = '0;
  logic [3:0]  ct_b;
  logic        err_a, err_b;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: per-frame hit total; saturation applied only when a report is formed.
  bit m_in, m_rep, m_err;
  int m_hits, m_pt, m_ct, m_fid;
  int m_cnt_a, m_cnt_b;
  bit m_det_a, m_det_b;

  motion_detector_if #(.COUNT_WIDTH(20)) bus_a ();
  motion_detector_if #(.COUNT_WIDTH(4))  bus_b ();

  assign ct_b = ct[3:0];

  motion_detector #(.COUNT_WIDTH(20)) u_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .pixel_threshold(pt), .count_threshold(ct), .frame_error(err_a)
  );

  motion_detector #(.COUNT_WIDTH(4)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .pixel_threshold(pt), .count_threshold(ct_b), .frame_error(err_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_rep = 0; m_err = 0; m_hits = 0; m_fid = 0;
    m_cnt_a = 0; m_cnt_b = 0; m_det_a = 0; m_det_b = 0;
  endtask

  task automatic model_step(input bit v, input bit s, input bit e, input int d, input bit rdy);
    bit close;
    close = 0;
    m_err = 0;
    if (m_rep) begin
      if (v) m_err = 1;
      if (rdy) begin
        m_rep = 0;
        m_fid = (m_fid + 1) % 65536;
      end
    end else if (v) begin
      if (s) begin
        if (m_in) m_err = 1;
        m_pt = int'(pt);
        m_ct = int'(ct);
        m_hits = (d > m_pt) ? 1 : 0;
        m_in = 1;
        close = e;
      end else if (m_in) begin
        m_hits += (d > m_pt) ? 1 : 0;
        close = e;
      end else begin
        m_err = 1;
      end
      if (close) begin
        m_in = 0;
        m_rep = 1;
        m_cnt_a = (m_hits > 1048575) ? 1048575 : m_hits;
        m_cnt_b = (m_hits > 15) ? 15 : m_hits;
        m_det_a = m_cnt_a >= m_ct;
        m_det_b = m_cnt_b >= (m_ct % 16);
      end
    end
  endtask

  // One input beat to both detectors, then the model advances over the same edge.
  task automatic beat(input bit v, input bit s, input bit e, input int d, input bit rdy);
    bus_a.diff_valid = v; bus_a.sof = s; bus_a.eof = e;
    bus_a.diff_data = 8'(d); bus_a.motion_ready = rdy;
    bus_b.diff_valid = v; bus_b.sof = s; bus_b.eof = e;
    bus_b.diff_data = 8'(d); bus_b.motion_ready = rdy;
    @(posedge clk);
    #1;
    model_step(v, s, e, d, rdy);
    bus_a.diff_valid = 0; bus_b.diff_valid = 0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) beat(0, 0, 0, 0, rdy);
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    reset = 1;
    #1;
    chk({tag, "_valid"}, bus_a.motion_valid, 0);
    chk({tag, "_count"}, bus_a.motion_count, 0);
    chk({tag, "_det"}, bus_a.motion_detected, 0);
    chk({tag, "_fid"}, bus_a.frame_id, 0);
    chk({tag, "_err"}, err_a, 0);
    model_reset();
    #3;
    reset = 0;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("valid_a", bus_a.motion_valid, m_rep);
    chk("valid_b", bus_b.motion_valid, m_rep);
    chk("ferr_a", err_a, m_err);
    chk("ferr_b", err_b, m_err);
    chk("fid_a", bus_a.frame_id, m_fid);
    if (m_rep) begin
      chk("count_a", bus_a.motion_count, m_cnt_a);
      chk("count_b", bus_b.motion_count, m_cnt_b);
      chk("det_a", bus_a.motion_detected, m_det_a);
      chk("det_b", bus_b.motion_detected, m_det_b);
      chk("fid_b", bus_b.frame_id, m_fid);
    end
  end

  initial begin
    bus_a.diff_valid = 0; bus_a.sof = 0; bus_a.eof = 0; bus_a.diff_data = 0; bus_a.motion_ready = 0;
    bus_b.diff_valid = 0; bus_b.sof = 0; bus_b.eof = 0; bus_b.diff_data = 0; bus_b.motion_ready = 0;
    model_reset();
    #13;
    chk("rst_valid", bus_a.motion_valid, 0);
    chk("rst_count", bus_a.motion_count, 0);
    chk("rst_det", bus_a.motion_detected, 0);
    chk("rst_fid", bus_a.frame_id, 0);
    chk("rst_err", err_a, 0);
    reset = 0;

    // Basic 4-pixel frame.
    pt = 50; ct = 2;
    beat(1, 1, 0, 10, 0); beat(1, 0, 0, 50, 0); beat(1, 0, 0, 200, 0); beat(1, 0, 1, 51, 0);
    chk("t1_valid", bus_a.motion_valid, 1);
    chk("t1_count", bus_a.motion_count, 2);
    chk("t1_det", bus_a.motion_detected, 1);
    chk("t1_fid", bus_a.frame_id, 0);
    idle(2, 0);
    beat(0, 0, 0, 0, 1);
    chk("t1_after", bus_a.motion_valid, 0);

    // Thresholds latched at sof; report held while ready is low.
    ct = 3;
    beat(1, 1, 0, 10, 0);
    pt = 0; ct = 0;
    beat(1, 0, 0, 50, 0); beat(1, 0, 0, 200, 0); beat(1, 0, 1, 51, 0);
    idle(5, 0);
    chk("t2_count", bus_a.motion_count, 2);
    chk("t2_det", bus_a.motion_detected, 0);
    chk("t2_fid", bus_a.frame_id, 1);
    beat(0, 0, 0, 0, 1);

    // sof inside a frame restarts the count.
    pt = 50; ct = 1;
    beat(1, 1, 0, 100, 0); beat(1, 0, 0, 100, 0);
    beat(1, 1, 0, 0, 0);
    chk("t3_ferr", err_a, 1);
    beat(1, 0, 0, 60, 0); beat(1, 0, 1, 10, 0);
    chk("t3_count", bus_a.motion_count, 1);
    beat(0, 0, 0, 0, 1);

    // Saturation in the 4-bit instance.
    pt = 0; ct = 5;
    beat(1, 1, 0, 255, 0);
    for (int i = 0; i < 18; i++) beat(1, 0, 0, 255, 0);
    beat(1, 0, 1, 255, 0);
    chk("t4_count_b", bus_b.motion_count, 15);
    chk("t4_det_b", bus_b.motion_detected, 1);
    chk("t4_count_a", bus_a.motion_count, 20);
    beat(0, 0, 0, 0, 1);

    // One-pixel frame; pixels during the report are dropped and flagged.
    pt = 8; ct = 1;
    beat(1, 1, 1, 9, 0);
    chk("t5_count", bus_a.motion_count, 1);
    chk("t5_valid", bus_a.motion_valid, 1);
    beat(1, 0, 0, 200, 0);
    chk("t5_ferr", err_a, 1);
    beat(1, 1, 0, 200, 1);
    beat(1, 0, 0, 30, 0);
    chk("t5_idle_ferr", err_a, 1);

    // Zero count threshold always reports motion; back-to-back frames.
    pt = 255; ct = 0;
    beat(1, 1, 0, 3, 0); beat(1, 0, 1, 4, 1);
    chk("t6_det", bus_a.motion_detected, 1);
    beat(0, 0, 0, 0, 1);
    beat(1, 1, 1, 0, 0);
    chk("t6_b2b_valid", bus_a.motion_valid, 1);
    beat(0, 0, 0, 0, 1);

    // Reset mid-frame and mid-report.
    pt = 10; ct = 2;
    beat(1, 1, 0, 50, 0); beat(1, 0, 0, 50, 0);
    async_reset_check("rst_accum");
    beat(1, 1, 0, 50, 0); beat(1, 0, 1, 5, 0);
    idle(1, 0);
    async_reset_check("rst_report");
    beat(1, 1, 0, 5, 0); beat(1, 0, 1, 11, 0);
    chk("t7_count", bus_a.motion_count, 1);
    chk("t7_fid", bus_a.frame_id, 0);
    beat(0, 0, 0, 0, 1);
    idle(2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/motion_detector.md
# motion_detector

Frame-level motion detector sitting directly downstream of the frame-difference subtractor. Consumes the per-pixel absolute-difference stream, counts pixels whose difference exceeds a programmable pixel threshold across one frame, and issues one motion report per frame (hit count plus motion flag) to the control logic over a valid/ready handshake.

## Interface
- DATA_WIDTH, 8, width of a difference pixel.
- COUNT_WIDTH, 20, width of the per-frame hit counter and count threshold.
- FRAME_ID_WIDTH, 16, width of the frame index counter.

- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- diff_data  input  DATA_WIDTH  absolute pixel difference from the subtractor.
- diff_valid  input  1  diff_data, sof and eof are valid this cycle.
- sof  input  1  first pixel of a frame; qualified by diff_valid.
- eof  input  1  last pixel of a frame; qualified by diff_valid.
- pixel_threshold  input  DATA_WIDTH  a pixel is a hit when diff_data > pixel_threshold.
- count_threshold  input  COUNT_WIDTH  motion when frame hit count >= count_threshold.
- motion_valid  output  1  report available.
- motion_ready  input  1  consumer accepts report.
- motion_detected  output  1  report flag.
- motion_count  output  COUNT_WIDTH  report hit count.
- frame_id  output  FRAME_ID_WIDTH  index of the reported frame.
- frame_error  output  1  one-cycle pulse on framing violation.

## Operation
- States: IDLE, ACCUM, REPORT.
- IDLE: non-sof valid pixels dropped and pulse frame_error. On diff_valid && sof: latch pixel_threshold and count_threshold, load count = hit(this pixel), go ACCUM; if eof also set (one-pixel frame), go directly to REPORT.
- ACCUM: each diff_valid pixel adds hit to count. Counter saturates at 2^COUNT_WIDTH-1, never wraps. On eof: include that pixel, go REPORT.
- ACCUM, sof without a preceding eof: pulse frame_error, discard partial frame, restart count from this pixel with newly latched thresholds.
- REPORT: motion_valid=1; motion_count = final count; motion_detected = (final count >= latched count_threshold); outputs stable until motion_valid && motion_ready, then go IDLE and increment the frame index (wraps modulo 2^FRAME_ID_WIDTH).
- REPORT: all incoming pixels dropped; any diff_valid pulses frame_error. Upstream must not start a new frame before the report is accepted.
- Thresholds changing mid-frame have no effect until the next sof.
- count_threshold = 0: every frame reports motion_detected=1.
- diff_valid=0 cycles are ignored in every state.

## Timing
- Reset: state IDLE, count 0, motion_valid 0, motion_detected 0, motion_count 0, frame_id 0, frame_error 0.
- Report latency: motion_valid rises the cycle after the eof beat.
- Handshake: transfer on the rising edge where motion_valid && motion_ready; motion_valid low the following cycle. motion_ready while motion_valid=0 is ignored.
- Back-to-back: earliest next sof accepted is the cycle after transfer (the first cycle back in IDLE).
- frame_error: registered, high exactly one cycle after the offending beat.
- frame_id: reflects the frame being reported; increments on the transfer edge.
- Reset mid-frame or mid-report: immediate return to reset values; partial frame and pending report discarded.

## Structure
- Shared package motion_pkg: state enum motion_state_t (IDLE, ACCUM, REPORT) and default width constants, shared with the subtractor-side control.
- One sub-module: sat_counter (parameterized width; load, increment and saturate) for the hit counter.
- Registered outputs only; no combinational path from the diff_* inputs to any output.

## Test plan
- 4-pixel frame, diffs 10,50,200,51, pixel_threshold=50, count_threshold=2 -> one cycle after eof: motion_valid=1, motion_count=2, motion_detected=1, frame_id=0.
- Same frame with count_threshold=3 and motion_ready held low 5 cycles -> report stable for all 5 cycles, transfer on ready, frame_id=1 on next report.
- sof in ACCUM after 2 hits -> frame_error pulse, count restarts; final report covers only the new frame.
- COUNT_WIDTH=4, 20 pixels of 255, pixel_threshold=0 -> motion_count=15 (saturated), motion_detected=1.
- Single pixel with sof=eof=1, diff 9, pixel_threshold=8 -> motion_count=1 the next cycle; pixels during REPORT are dropped and pulse frame_error.
- reset asserted mid-ACCUM and mid-REPORT -> all outputs return to 0 asynchronously; the next frame reports from a zero count with frame_id=0.
